cache_miss_controller: RTL and testbench
========================================

# cache_miss_controller

Sequencing controller for the data-side two-way set-associative cache in the RISC-V CPU. It takes the CPU's load/store requests, uses the cache's combinational hit result, stalls the pipeline on read misses and on all stores, and runs a req/ack handshake to main memory. It drives the cache refill write port: fill on a read miss, update on a store hit. The cache is write-through with no write-allocate.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width.
- CNT_WIDTH, 16, width of the hit and miss statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cpu_req_i  input  1  CPU access valid; held stable while stall_o=1.
- cpu_we_i  input  1  1 = store, 0 = load.
- cpu_addr_i  input  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- cpu_wdata_i  input  DATA_WIDTH  store data.
- cpu_rdata_o  output  DATA_WIDTH  load data to the CPU.
- stall_o  output  1  pipeline stall, combinational.
- cache_hit_i  input  1  hit flag from the cache for cpu_addr_i.
- cache_rdata_i  input  DATA_WIDTH  cache read data for cpu_addr_i.
- fill_en_o  output  1  one-cycle cache write strobe.
- fill_addr_o  output  ADDR_WIDTH  cache write address, word-aligned.
- fill_data_o  output  DATA_WIDTH  cache write data.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  memory write qualifier.
- mem_addr_o  output  ADDR_WIDTH  memory address, bits [1:0]=0.
- mem_wdata_o  output  DATA_WIDTH  memory write data.
- mem_ack_i  input  1  memory completion; valid only while mem_req_o=1.
- mem_rdata_i  input  DATA_WIDTH  read data, valid in the ack cycle.
- hit_count_o  output  CNT_WIDTH  number of load hits.
- miss_count_o  output  CNT_WIDTH  number of load misses.

## Operation
States: IDLE, RD_MISS, FILL, WR_MEM, WR_DONE.

- **IDLE, load hit** (cpu_req_i=1, cpu_we_i=0, cache_hit_i=1):
  - cpu_rdata_o=cache_rdata_i, stall_o=0.
  - hit_count increments; state stays IDLE.
- **IDLE, load miss** (cache_hit_i=0):
  - stall_o=1; latch the word address.
  - miss_count increments; next state RD_MISS.
- **IDLE, store:**
  - stall_o=1; latch address, data and cache_hit_i.
  - Next state WR_MEM.
- **RD_MISS:**
  - mem_req_o=1, mem_we_o=0, mem_addr_o=latched address, stall_o=1.
  - On mem_ack_i, capture mem_rdata_i into the line register and go to FILL.
- **FILL:**
  - fill_en_o=1; fill_addr_o and fill_data_o come from the latched address and the line register.
  - cpu_rdata_o=line register, stall_o=0.
  - Next state IDLE. cpu_req_i in this cycle belongs to the completing access and is not re-evaluated.
- **WR_MEM:**
  - mem_req_o=1, mem_we_o=1, mem_wdata_o=latched data, stall_o=1.
  - On mem_ack_i go to WR_DONE.
- **WR_DONE:**
  - stall_o=0; fill_en_o=latched hit flag, carrying the latched address and data.
  - Next state IDLE. A store miss never writes the cache.
- **Idle outputs:** when idle with no request, stall_o=0 and fill_en_o=0.
- **Memory outputs:** mem_req_o, mem_we_o and mem_addr_o come from registered state only; they never depend combinationally on cpu_* inputs.
- **Address alignment:** all addresses sent to the cache and to memory have bits [1:0]=0.
- **Statistics counters:**
  - Only loads in IDLE are counted; stores are not counted.
  - Each counter wraps from 2^CNT_WIDTH-1 to 0.
- **Unused outputs:** cpu_rdata_o is 0 in every state except IDLE and FILL. fill_*, mem_wdata_o and mem_addr_o are 0 whenever their strobe or request is low.

## Timing
- **Reset:**
  - rst_n=0 asynchronously forces IDLE; all latches and both counters go to 0.
  - mem_req_o, mem_we_o and fill_en_o drop to 0 immediately, even mid-transaction.
  - The in-flight memory access is abandoned and its late ack is ignored, since ack is only valid with req.
- **Load hit:** 0 stall cycles; data is returned in the request cycle.
- **Load miss:**
  - mem_req_o rises in the cycle after the request.
  - If ack arrives W cycles after req rises (W≥0, with ack in the first req cycle meaning W=0), stall lasts 2+W cycles; FILL is the first unstalled cycle.
- **Store:** stall lasts 2+W cycles, and fill_en_o, if set, pulses in the WR_DONE cycle.
- **Handshake:**
  - mem_req_o stays asserted with stable address and data until the cycle in which mem_ack_i is sampled.
  - mem_req_o deasserts in the next cycle; the controller never issues back-to-back requests without passing through IDLE.
- fill_en_o is asserted for exactly one cycle per refill or update.

## Test plan
- **Reset:** assert rst_n=0 while in RD_MISS with mem_req_o=1 → mem_req_o=0 in the same cycle; after release, state is IDLE and hit_count_o=miss_count_o=0.
- **Load hit:** load addr 0x100, cache_hit_i=1, cache_rdata_i=0xDEADBEEF → cpu_rdata_o=0xDEADBEEF, stall_o=0, hit_count_o=1.
- **Load miss:** load addr 0x207 missing, mem_ack_i 3 cycles after req, mem_rdata_i=0x12345678 →
  - mem_addr_o=0x204 and stall_o=1 for 5 cycles;
  - then fill_en_o pulses with fill_addr_o=0x204, fill_data_o=0x12345678, cpu_rdata_o=0x12345678;
  - miss_count_o=1.
- **Store hit:** store 0xCAFEF00D to 0x40, hit, ack in the first req cycle →
  - mem_we_o=1, mem_wdata_o=0xCAFEF00D;
  - stall_o=1 for 2 cycles, then fill_en_o=1 with addr 0x40;
  - a store miss with the same stimulus gives fill_en_o=0.
- **Back-to-back:** load miss followed immediately by a load hit → the hit is served in the cycle after FILL with no extra stall.
- **Counter wrap:** CNT_WIDTH=4 with 17 load hits → hit_count_o=1.

Source files
------------

// File: rtl/cache_miss_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_controller_if
//  Description : Main-memory req/ack bus between the data-cache miss
//                controller (master) and the memory system (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_miss_controller_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_ack_i;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   // Controller side: issues requests, receives completion and read data.
   modport master (
      output mem_req_o,
      output mem_we_o,
      output mem_addr_o,
      output mem_wdata_o,
      input  mem_ack_i,
      input  mem_rdata_i
   );

   // Memory side: observes requests, returns completion and read data.
   modport slave (
      input  mem_req_o,
      input  mem_we_o,
      input  mem_addr_o,
      input  mem_wdata_o,
      output mem_ack_i,
      output mem_rdata_i
   );
endinterface
`default_nettype wire

// File: rtl/cache_miss_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_controller
//  Description : Sequencer for a write-through, no-write-allocate data cache.
//                Serves load hits without stalling, refills on load misses,
//                writes every store through to memory and updates the cache
//                only on store hits. Counts load hits and load misses.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_miss_controller #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // CPU side
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   output logic                  stall_o,
   // Cache lookup result and refill/update port
   input  logic                  cache_hit_i,
   input  logic [DATA_WIDTH-1:0] cache_rdata_i,
   output logic                  fill_en_o,
   output logic [ADDR_WIDTH-1:0] fill_addr_o,
   output logic [DATA_WIDTH-1:0] fill_data_o,
   // Main-memory bus
   cache_miss_controller_if.master mem_if,
   // Statistics
   output logic [CNT_WIDTH-1:0]  hit_count_o,
   output logic [CNT_WIDTH-1:0]  miss_count_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_MISS = 3'd1,
      FILL    = 3'd2,
      WR_MEM  = 3'd3,
      WR_DONE = 3'd4
   } state_t;

   state_t                state_q,    state_d;
   logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic [DATA_WIDTH-1:0] data_q,     data_d;
   logic                  hit_flag_q, hit_flag_d;
   logic [DATA_WIDTH-1:0] line_q,     line_d;
   logic [CNT_WIDTH-1:0]  hit_cnt_q,  hit_cnt_d;
   logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

   // Byte offset is irrelevant to a word-organised cache and memory.
   logic [ADDR_WIDTH-1:0] addr_aligned;
   logic [1:0]            addr_lsb_unused;
   assign addr_aligned    = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign addr_lsb_unused = cpu_addr_i[1:0];

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;

   // State and latched transaction registers; reset abandons any access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         hit_flag_q <= 1'b0;
         line_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         hit_flag_q <= hit_flag_d;
         line_q     <= line_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Next-state and output decode; memory outputs depend on state_q only.
   always_comb begin
      state_d            = state_q;
      addr_d             = addr_q;
      data_d             = data_q;
      hit_flag_d         = hit_flag_q;
      line_d             = line_q;
      hit_cnt_d          = hit_cnt_q;
      miss_cnt_d         = miss_cnt_q;
      cpu_rdata_o        = '0;
      stall_o            = 1'b0;
      fill_en_o          = 1'b0;
      fill_addr_o        = '0;
      fill_data_o        = '0;
      mem_if.mem_req_o   = 1'b0;
      mem_if.mem_we_o    = 1'b0;
      mem_if.mem_addr_o  = '0;
      mem_if.mem_wdata_o = '0;

      unique case (state_q)
         IDLE: begin
            if (cpu_req_i) begin
               if (cpu_we_i) begin
                  // Every store goes to memory; remember whether the cache
                  // holds the word so it can be updated afterwards.
                  stall_o    = 1'b1;
                  addr_d     = addr_aligned;
                  data_d     = cpu_wdata_i;
                  hit_flag_d = cache_hit_i;
                  state_d    = WR_MEM;
               end else if (cache_hit_i) begin
                  cpu_rdata_o = cache_rdata_i;
                  hit_cnt_d   = hit_cnt_q + 1'b1;
               end else begin
                  stall_o    = 1'b1;
                  addr_d     = addr_aligned;
                  miss_cnt_d = miss_cnt_q + 1'b1;
                  state_d    = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            stall_o           = 1'b1;
            mem_if.mem_req_o  = 1'b1;
            mem_if.mem_addr_o = addr_q;
            if (mem_if.mem_ack_i) begin
               line_d  = mem_if.mem_rdata_i;
               state_d = FILL;
            end
         end
         FILL: begin
            // The CPU request seen here is the one being completed.
            fill_en_o   = 1'b1;
            fill_addr_o = addr_q;
            fill_data_o = line_q;
            cpu_rdata_o = line_q;
            state_d     = IDLE;
         end
         WR_MEM: begin
            stall_o            = 1'b1;
            mem_if.mem_req_o   = 1'b1;
            mem_if.mem_we_o    = 1'b1;
            mem_if.mem_addr_o  = addr_q;
            mem_if.mem_wdata_o = data_q;
            if (mem_if.mem_ack_i) begin
               state_d = WR_DONE;
            end
         end
         WR_DONE: begin
            // No write-allocate: only a store hit touches the cache.
            if (hit_flag_q) begin
               fill_en_o   = 1'b1;
               fill_addr_o = addr_q;
               fill_data_o = data_q;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_miss_controller
//  Description : Self-checking bench for cache_miss_controller. Two DUTs share
//                the stimulus: a 16-bit-counter one checked in full and a
//                4-bit-counter one used for counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_miss_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cache_hit = 1'b0;
   logic [31:0] cache_rdata = '0;
   logic        ack = 1'b0;
   logic [31:0] mrdata = '0;

   logic [31:0] cpu_rdata,   cpu_rdata_s;
   logic        stall,       stall_s;
   logic        fill_en,     fill_en_s;
   logic [31:0] fill_addr,   fill_addr_s;
   logic [31:0] fill_data,   fill_data_s;
   logic [15:0] hit_cnt,     miss_cnt;
   logic [3:0]  hit_cnt_s,   miss_cnt_s;

   int n_checks = 0;
   int n_fail   = 0;
   // Reference model: plain counts of load hits and load misses.
   int m_hits   = 0;
   int m_miss   = 0;

   cache_miss_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();
   cache_miss_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif_s ();
   assign mif.mem_ack_i     = ack;
   assign mif.mem_rdata_i   = mrdata;
   assign mif_s.mem_ack_i   = ack;
   assign mif_s.mem_rdata_i = mrdata;

   cache_miss_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .stall_o(stall),
      .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata),
      .fill_en_o(fill_en), .fill_addr_o(fill_addr), .fill_data_o(fill_data),
      .mem_if(mif.master),
      .hit_count_o(hit_cnt), .miss_count_o(miss_cnt)
   );

   cache_miss_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata_s), .stall_o(stall_s),
      .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata),
      .fill_en_o(fill_en_s), .fill_addr_o(fill_addr_s), .fill_data_o(fill_data_s),
      .mem_if(mif_s.master),
      .hit_count_o(hit_cnt_s), .miss_count_o(miss_cnt_s)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One cycle with no request: controller must be quiet.
   task automatic idle_cycle();
      cpu_req     = 1'b0;
      cpu_we      = 1'($urandom);
      cpu_addr    = $urandom;
      cache_hit   = 1'($urandom);
      cache_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if ({stall, fill_en, mif.mem_req_o, mif.mem_we_o} !== 4'b0000 || mif.mem_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL idle: stall/fill_en/req/we=%b%b%b%b addr=%h required 0000/0",
                  stall, fill_en, mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o);
      end
      next_cycle();
   endtask

   task automatic load_hit(input logic [31:0] a, input logic [31:0] d);
      logic [15:0] eh;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = $urandom;
      cache_hit = 1'b1; cache_rdata = d;
      @(negedge clk);
      n_checks++;
      if (cpu_rdata !== d || stall !== 1'b0 || fill_en !== 1'b0 || mif.mem_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL load_hit: rdata=%h stall=%b fill=%b req=%b required %h/0/0/0",
                  cpu_rdata, stall, fill_en, mif.mem_req_o, d);
      end
      m_hits++;
      next_cycle();
      eh = m_hits[15:0];
      n_checks++;
      if (hit_cnt !== eh || miss_cnt !== m_miss[15:0] || hit_cnt_s !== eh[3:0] || miss_cnt_s !== m_miss[3:0]) begin
         n_fail++;
         $display("FAIL load_hit_counts: hit=%0d miss=%0d hit4=%0d miss4=%0d required %0d/%0d/%0d/%0d",
                  hit_cnt, miss_cnt, hit_cnt_s, miss_cnt_s, eh, m_miss[15:0], eh[3:0], m_miss[3:0]);
      end
   endtask

   task automatic load_miss(input logic [31:0] a, input int w, input logic [31:0] rd);
      logic [31:0] wa;
      int stalls;
      wa = {a[31:2], 2'b00};
      stalls = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = $urandom;
      cache_hit = 1'b0; cache_rdata = $urandom; ack = 1'b0;
      @(negedge clk);
      if (stall) stalls++;
      n_checks++;
      if (mif.mem_req_o !== 1'b0 || fill_en !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_request_cycle: req=%b fill=%b required 0/0", mif.mem_req_o, fill_en);
      end
      m_miss++;
      next_cycle();
      for (int k = 0; k <= w; k++) begin
         ack    = (k == w);
         mrdata = (k == w) ? rd : $urandom;
         @(negedge clk);
         if (stall) stalls++;
         n_checks++;
         if (mif.mem_req_o !== 1'b1 || mif.mem_we_o !== 1'b0 || mif.mem_addr_o !== wa ||
             mif.mem_wdata_o !== 32'h0 || cpu_rdata !== 32'h0 || fill_en !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_mem_req: req=%b we=%b addr=%h wdata=%h rdata=%h fill=%b required 1/0/%h/0/0/0",
                     mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o, cpu_rdata, fill_en, wa);
         end
         next_cycle();
      end
      ack = 1'b0;
      mrdata = $urandom;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || fill_en !== 1'b1 || fill_addr !== wa || fill_data !== rd ||
          cpu_rdata !== rd || mif.mem_req_o !== 1'b0 || mif.mem_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL miss_fill: stall=%b fill=%b faddr=%h fdata=%h rdata=%h req=%b maddr=%h required 0/1/%h/%h/%h/0/0",
                  stall, fill_en, fill_addr, fill_data, cpu_rdata, mif.mem_req_o, mif.mem_addr_o, wa, rd, rd);
      end
      n_checks++;
      if (stalls !== w + 2) begin
         n_fail++;
         $display("FAIL miss_stall_len: stalled %0d cycles required %0d", stalls, w + 2);
      end
      next_cycle();
      n_checks++;
      if (hit_cnt !== m_hits[15:0] || miss_cnt !== m_miss[15:0] || hit_cnt_s !== m_hits[3:0] || miss_cnt_s !== m_miss[3:0]) begin
         n_fail++;
         $display("FAIL miss_counts: hit=%0d miss=%0d hit4=%0d miss4=%0d required %0d/%0d/%0d/%0d",
                  hit_cnt, miss_cnt, hit_cnt_s, miss_cnt_s, m_hits[15:0], m_miss[15:0], m_hits[3:0], m_miss[3:0]);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic h, input int w);
      logic [31:0] wa;
      int stalls;
      wa = {a[31:2], 2'b00};
      stalls = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      cache_hit = h; cache_rdata = $urandom; ack = 1'b0;
      @(negedge clk);
      if (stall) stalls++;
      n_checks++;
      if (mif.mem_req_o !== 1'b0 || fill_en !== 1'b0) begin
         n_fail++;
         $display("FAIL store_request_cycle: req=%b fill=%b required 0/0", mif.mem_req_o, fill_en);
      end
      next_cycle();
      for (int k = 0; k <= w; k++) begin
         ack    = (k == w);
         mrdata = $urandom;
         @(negedge clk);
         if (stall) stalls++;
         n_checks++;
         if (mif.mem_req_o !== 1'b1 || mif.mem_we_o !== 1'b1 || mif.mem_addr_o !== wa ||
             mif.mem_wdata_o !== d || cpu_rdata !== 32'h0 || fill_en !== 1'b0) begin
            n_fail++;
            $display("FAIL store_mem_req: req=%b we=%b addr=%h wdata=%h rdata=%h fill=%b required 1/1/%h/%h/0/0",
                     mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o, cpu_rdata, fill_en, wa, d);
         end
         next_cycle();
      end
      ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || fill_en !== h || fill_addr !== (h ? wa : 32'h0) ||
          fill_data !== (h ? d : 32'h0) || cpu_rdata !== 32'h0 || mif.mem_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL store_done: stall=%b fill=%b faddr=%h fdata=%h rdata=%h req=%b required 0/%b/%h/%h/0/0",
                  stall, fill_en, fill_addr, fill_data, cpu_rdata, mif.mem_req_o,
                  h, (h ? wa : 32'h0), (h ? d : 32'h0));
      end
      n_checks++;
      if (stalls !== w + 2) begin
         n_fail++;
         $display("FAIL store_stall_len: stalled %0d cycles required %0d", stalls, w + 2);
      end
      next_cycle();
      n_checks++;
      if (hit_cnt !== m_hits[15:0] || miss_cnt !== m_miss[15:0]) begin
         n_fail++;
         $display("FAIL store_counts: hit=%0d miss=%0d required %0d/%0d",
                  hit_cnt, miss_cnt, m_hits[15:0], m_miss[15:0]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) next_cycle();
      n_checks++;
      if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || mif.mem_req_o !== 1'b0 || fill_en !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_initial: hit=%0d miss=%0d req=%b fill=%b stall=%b required all 0",
                  hit_cnt, miss_cnt, mif.mem_req_o, fill_en, stall);
      end
      rst_n = 1'b1;
      next_cycle();
      load_hit(32'h0000_0300, $urandom);
      // Enter RD_MISS, then reset mid-transaction.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500; cache_hit = 1'b0;
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (mif.mem_req_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_setup: req=%b required 1", mif.mem_req_o);
      end
      #1;
      rst_n = 1'b0;
      cpu_req = 1'b0;
      ack = 1'b1;
      #1;
      n_checks++;
      if (mif.mem_req_o !== 1'b0 || mif.mem_we_o !== 1'b0 || fill_en !== 1'b0 ||
          hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || hit_cnt_s !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_async: req=%b we=%b fill=%b hit=%0d miss=%0d hit4=%0d required 0/0/0/0/0/0",
                  mif.mem_req_o, mif.mem_we_o, fill_en, hit_cnt, miss_cnt, hit_cnt_s);
      end
      m_hits = 0;
      m_miss = 0;
      next_cycle();
      rst_n = 1'b1;
      // Late ack arrives after release: must be ignored.
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (mif.mem_req_o !== 1'b0 || stall !== 1'b0 || fill_en !== 1'b0 || cpu_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_late_ack: req=%b stall=%b fill=%b rdata=%h required 0/0/0/0",
                  mif.mem_req_o, stall, fill_en, cpu_rdata);
      end
      ack = 1'b0;
      next_cycle();
   endtask

   task automatic test_load_hit();
      load_hit(32'h0000_0100, 32'hDEAD_BEEF);
      n_checks++;
      if (hit_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL first_hit_count: hit=%0d required 1", hit_cnt);
      end
      idle_cycle();
   endtask

   task automatic test_load_miss();
      load_miss(32'h0000_0207, 3, 32'h1234_5678);
      n_checks++;
      if (miss_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL first_miss_count: miss=%0d required 1", miss_cnt);
      end
      idle_cycle();
   endtask

   task automatic test_store();
      store(32'h0000_0040, 32'hCAFE_F00D, 1'b1, 0);
      idle_cycle();
      store(32'h0000_0040, 32'hCAFE_F00D, 1'b0, 0);
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      load_miss(32'h0000_1000, 1, 32'hA5A5_0001);
      load_hit(32'h0000_2004, 32'h5A5A_0002);
      store(32'h0000_3008, 32'h0BAD_CAFE, 1'b1, 2);
      load_miss(32'h0000_400B, 0, 32'h7777_8888);
      idle_cycle();
   endtask

   task automatic test_counter_wrap();
      int h0;
      h0 = m_hits;
      for (int i = 0; i < 17; i++) load_hit($urandom, $urandom);
      n_checks++;
      if (hit_cnt_s !== 4'((h0 + 17) % 16)) begin
         n_fail++;
         $display("FAIL counter_wrap: hit4=%0d required %0d", hit_cnt_s, (h0 + 17) % 16);
      end
      idle_cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: load_hit($urandom, $urandom);
            1: load_miss($urandom, int'($urandom_range(0, 4)), $urandom);
            2: store($urandom, $urandom, 1'b1, int'($urandom_range(0, 4)));
            default: store($urandom, $urandom, 1'b0, int'($urandom_range(0, 4)));
         endcase
         repeat ($urandom_range(0, 2)) idle_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_load_hit();
      test_load_miss();
      test_store();
      test_back_to_back();
      test_counter_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
